// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order request tagging,
// a small instruction queue toward decode, and redirect flush with stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   qInstr_q [DEPTH];
  logic [31:0]   qPc_q    [DEPTH];
  logic [31:0]   tag_q    [DEPTH];
  logic [PW-1:0] qRd_q, qRd_d, qWr_q, qWr_d;
  logic [PW-1:0] tagRd_q, tagRd_d, tagWr_q, tagWr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic          accept, pop, push, dropResp;

  // Pops are deliberately not credited so the request decision never depends on instr_ready.
  assign imem_req    = !reset && !redirect_valid &&
                       (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_SUM);
  assign imem_addr   = fetchPc_q;
  assign accept      = imem_req && imem_ready;
  assign instr_valid = (count_q != '0);
  assign instruction = qInstr_q[qRd_q];
  assign instr_pc    = qPc_q[qRd_q];
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign push        = imem_rvalid && !redirect_valid && !dropResp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (discard_d != '0) ? DRAIN : FETCH;
    end else if (state_q == DRAIN && discard_d == '0) begin
      state_d = FETCH;
    end
  end

  always_comb begin
    dropResp = 1'b0;
    if (state_q == DRAIN) begin
      dropResp = imem_rvalid;
    end
  end

  // The tag FIFO pops on every response, dropped or not, so it always mirrors outst_q.
  always_comb begin
    fetchPc_d = fetchPc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    qRd_d     = qRd_q;
    qWr_d     = qWr_q;
    tagWr_d   = tagWr_q + PW'(accept);
    tagRd_d   = tagRd_q + PW'(imem_rvalid);
    if (redirect_valid) begin
      fetchPc_d = {redirect_pc[31:2], 2'b00};
      outst_d   = outst_q - CW'(imem_rvalid);
      discard_d = outst_q - CW'(imem_rvalid);
      count_d   = '0;
      qRd_d     = '0;
      qWr_d     = '0;
    end else begin
      if (accept) begin
        fetchPc_d = fetchPc_q + 32'd4;
      end
      outst_d = outst_q + CW'(accept) - CW'(imem_rvalid);
      if (dropResp) begin
        discard_d = discard_q - CW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) begin
        qWr_d = qWr_q + PW'(1);
      end
      if (pop) begin
        qRd_d = qRd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      qRd_q     <= '0;
      qWr_q     <= '0;
      tagRd_q   <= '0;
      tagWr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qInstr_q[i] <= NOP;
        qPc_q[i]    <= RESET_PC;
        tag_q[i]    <= RESET_PC;
      end
    end else begin
      fetchPc_q <= fetchPc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      qRd_q     <= qRd_d;
      qWr_q     <= qWr_d;
      tagRd_q   <= tagRd_d;
      tagWr_q   <= tagWr_d;
      if (push) begin
        qInstr_q[qWr_q] <= imem_rdata;
        qPc_q[qWr_q]    <= tag_q[tagRd_q];
      end
      if (accept) begin
        tag_q[tagWr_q] <= fetchPc_q;
      end
    end
  end

  property noOverflow;
    @(posedge clk) disable iff (reset) !(push && !pop && count_q == DEPTH_CNT);
  endproperty
  queueOverflow: assert property (noOverflow);

endmodule
